// File: rtl/aes_pkg.sv
// Shared AES constants and the key-scheduler state encoding.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int KEY_W  = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } sched_state_e;

endpackage : aes_pkg

// File: rtl/aes_key_scheduler_if.sv
// Key-load handshake plus round-key read port between a key source /
// cipher core (master) and the key scheduler (slave).
interface aes_key_scheduler_if #(
  parameter int ADDR_W = 4
);
  import aes_pkg::*;

  logic [KEY_W-1:0]  key_in;
  logic              key_valid;
  logic              key_ready;
  logic              busy;
  logic              keys_ready;
  logic [ADDR_W-1:0] rk_addr;
  logic [KEY_W-1:0]  rk_data;

  modport master (
    output key_in, key_valid, rk_addr,
    input  key_ready, busy, keys_ready, rk_data
  );

  modport slave (
    input  key_in, key_valid, rk_addr,
    output key_ready, busy, keys_ready, rk_data
  );

endinterface : aes_key_scheduler_if

// File: rtl/aes_key_scheduler_keyexpansion.sv
// One AES-128 key-expansion step: RotWord/SubWord/Rcon on the last word,
// then the XOR chain across the four words. Purely combinational.
module keyexpansion
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] oldkey,
  input  logic [4:0]       round,
  output logic [KEY_W-1:0] newkey
);

  // Forward S-box, byte 0x00 in the top byte, 0xff in the bottom byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bit offset 8*(255-b); 255-b is simply ~b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  // Round constant for rounds 1..10; other inputs are never used by the caller.
  function automatic logic [7:0] rcon(input logic [4:0] r);
    logic [7:0] c;
    c = 8'h00;
    case (r)
      5'd1:  c = 8'h01;
      5'd2:  c = 8'h02;
      5'd3:  c = 8'h04;
      5'd4:  c = 8'h08;
      5'd5:  c = 8'h10;
      5'd6:  c = 8'h20;
      5'd7:  c = 8'h40;
      5'd8:  c = 8'h80;
      5'd9:  c = 8'h1b;
      5'd10: c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = oldkey;

  // SubWord(RotWord(w3)) xor Rcon, then the word-to-word XOR chain.
  always_comb begin
    // NOTE: combinational blocks assign every output on every path so no latch is inferred.
    temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rcon(round), 24'h000000};
    n0 = w0 ^ temp;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
  end

  assign newkey = {n0, n1, n2, n3};

endmodule : keyexpansion

// File: rtl/aes_key_scheduler.sv
// Iterative AES-128 key scheduler: loads a cipher key, expands one round
// key per cycle into a flat register file, and serves round keys through
// a registered random-access read port.
module aes_key_scheduler
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  aes_key_scheduler_if.slave bus
);

  localparam logic [ADDR_W-1:0] NR_A  = ADDR_W'(NR);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  sched_state_e      state_q;
  logic [ADDR_W-1:0] round_cnt_q;
  logic [KEY_W-1:0]  cur_key_q;
  logic [KEY_W-1:0]  rk_q [0:NR];
  logic              key_ready_q;
  logic              busy_q;
  logic              keys_ready_q;
  logic [KEY_W-1:0]  rk_data_q;

  logic              accept;
  logic [4:0]        ke_round;
  logic [KEY_W-1:0]  next_key_d;

  assign accept = bus.key_valid & key_ready_q;

  // Round input is parked at 1 outside EXPAND so the Rcon lookup always sees a legal round.
  assign ke_round = (state_q == ST_EXPAND) ? 5'(round_cnt_q) : 5'd1;

  keyexpansion u_keyexpansion (
    .oldkey (cur_key_q),
    .round  (ke_round),
    .newkey (next_key_d)
  );

  // Control FSM, expansion datapath and round-key register file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      round_cnt_q  <= '0;
      cur_key_q    <= '0;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      keys_ready_q <= 1'b0;
      // NOTE: the round-key file is plain flops, so it can and does take the reset; a RAM macro could not.
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            rk_q[0]      <= bus.key_in;
            cur_key_q    <= bus.key_in;
            round_cnt_q  <= ONE_A;
            state_q      <= ST_EXPAND;
            key_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            keys_ready_q <= 1'b0;
          end
        end
        ST_EXPAND: begin
          rk_q[round_cnt_q] <= next_key_d;
          cur_key_q         <= next_key_d;
          if (round_cnt_q == NR_A) begin
            state_q      <= ST_DONE;
            key_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            keys_ready_q <= 1'b1;
          end else begin
            round_cnt_q <= round_cnt_q + ONE_A;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Registered read port, live in every state; out-of-range indices read as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rk_data_q <= '0;
    end else begin
      rk_data_q <= (bus.rk_addr <= NR_A) ? rk_q[bus.rk_addr] : '0;
    end
  end

  assign bus.key_ready  = key_ready_q;
  assign bus.busy       = busy_q;
  assign bus.keys_ready = keys_ready_q;
  assign bus.rk_data    = rk_data_q;

endmodule : aes_key_scheduler

// File: tb/tb_aes_key_scheduler.sv
// Directed bench for the AES-128 key scheduler using FIPS-197 and all-zero key vectors.
module tb_aes_key_scheduler;
  import aes_pkg::*;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK4  = 128'hef44a541a8525b7fb671253bdb0bad00;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] JUNK_KEY  = 128'hdeadbeef0123456789abcdeffedcba98;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  aes_key_scheduler_if #(.ADDR_W(4)) bus_if ();

  aes_key_scheduler #(.NR(10), .ADDR_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a key at a falling edge and hold it until the scheduler takes it.
  task automatic send_key(input logic [127:0] key);
    int w;
    w = 0;
    while (!bus_if.key_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("key_ready_before_send", 128'(bus_if.key_ready), 128'd1);
    bus_if.key_in    = key;
    bus_if.key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.key_valid = 1'b0;
  endtask

  // From a falling edge, count clock edges until keys_ready; optionally pulse a stray key.
  task automatic wait_done(input int start, input bit inject, output int n, output int lo);
    n  = start;
    lo = 0;
    while (!bus_if.keys_ready && n < 40) begin
      if (!bus_if.key_ready) lo++;
      if (inject && n == 3) begin
        bus_if.key_in    = JUNK_KEY;
        bus_if.key_valid = 1'b1;
      end else begin
        bus_if.key_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    bus_if.key_valid = 1'b0;
    check("keys_ready_reached", 128'(bus_if.keys_ready), 128'd1);
  endtask

  task automatic read_rk(input logic [3:0] addr, output logic [127:0] data);
    bus_if.rk_addr = addr;
    @(posedge clk);
    @(negedge clk);
    data = bus_if.rk_data;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_ready"},  128'(bus_if.key_ready),  128'd1);
    check({tag, "_busy"},       128'(bus_if.busy),       128'd0);
    check({tag, "_keys_ready"}, 128'(bus_if.keys_ready), 128'd0);
    check({tag, "_rk_data"},    bus_if.rk_data,          128'd0);
  endtask

  initial begin
    int n;
    int lo;
    logic [127:0] d;

    checks = 0;
    errors = 0;
    reset_n          = 1'b0;
    bus_if.key_in    = '0;
    bus_if.key_valid = 1'b0;
    bus_if.rk_addr   = '0;

    // Reset held across several edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // FIPS key with a stray key pulsed mid-expansion.
    send_key(FIPS_KEY);
    check("accept_busy",      128'(bus_if.busy),      128'd1);
    check("accept_key_ready", 128'(bus_if.key_ready), 128'd0);
    wait_done(0, 1'b1, n, lo);
    check("fips_latency",       128'(n),  128'd10);
    check("fips_key_ready_low", 128'(lo), 128'd10);
    check("done_key_ready",     128'(bus_if.key_ready), 128'd1);
    check("done_busy",          128'(bus_if.busy),      128'd0);

    read_rk(4'd0,  d); check("fips_rk0",  d, FIPS_KEY);
    read_rk(4'd1,  d); check("fips_rk1",  d, FIPS_RK1);
    read_rk(4'd4,  d); check("fips_rk4",  d, FIPS_RK4);
    read_rk(4'd10, d); check("fips_rk10", d, FIPS_RK10);
    read_rk(4'd11, d); check("addr11_zero", d, 128'd0);
    read_rk(4'd15, d); check("addr15_zero", d, 128'd0);

    // Back-to-back all-zero key, reading rk[1] across its own overwrite.
    bus_if.rk_addr   = 4'd1;
    bus_if.key_in    = '0;
    bus_if.key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.key_valid = 1'b0;
    check("b2b_keys_ready_drop", 128'(bus_if.keys_ready), 128'd0);
    check("b2b_rk1_at_accept",   bus_if.rk_data, FIPS_RK1);
    @(posedge clk);
    @(negedge clk);
    check("b2b_rk1_prewrite",    bus_if.rk_data, FIPS_RK1);
    @(posedge clk);
    @(negedge clk);
    check("b2b_rk1_new",         bus_if.rk_data, ZERO_RK1);
    wait_done(2, 1'b0, n, lo);
    check("b2b_latency", 128'(n), 128'd10);
    read_rk(4'd0,  d); check("zero_rk0",  d, 128'd0);
    read_rk(4'd10, d); check("zero_rk10", d, ZERO_RK10);

    // Reset asserted at round 5 discards the partial schedule.
    send_key(FIPS_KEY);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_reset_busy", 128'(bus_if.busy), 128'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    read_rk(4'd10, d); check("midreset_rk10_cleared", d, 128'd0);
    read_rk(4'd0,  d); check("midreset_rk0_cleared",  d, 128'd0);

    // Re-issue the FIPS key after the abort.
    send_key(FIPS_KEY);
    wait_done(0, 1'b0, n, lo);
    check("reissue_latency", 128'(n), 128'd10);
    read_rk(4'd1,  d); check("reissue_rk1",  d, FIPS_RK1);
    read_rk(4'd4,  d); check("reissue_rk4",  d, FIPS_RK4);
    read_rk(4'd10, d); check("reissue_rk10", d, FIPS_RK10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_aes_key_scheduler
